// File: rtl/gl4_pkg.sv
// Shared defaults and arithmetic helpers for the gl4 video scaling path.
package gl4_pkg;

    localparam int GL4_D_WIDTH   = 8;
    localparam int GL4_MAX_WIDTH = 2048;
    localparam int AVG_W         = 18;

    // Rounded mean of four samples, round half up; callers zero-extend their sum to AVG_W.
    function automatic logic [AVG_W-1:0] avg4(input logic [AVG_W-1:0] sum);
        return (sum + AVG_W'(2)) >> 2;
    endfunction

endpackage

// File: rtl/gl4_line_buffer.sv
// One-line pixel store: single write port, asynchronous read, old data on same-address collision.
module gl4_line_buffer
    import gl4_pkg::*;
#(
    parameter int D_WIDTH   = GL4_D_WIDTH,
    parameter int MAX_WIDTH = GL4_MAX_WIDTH,
    localparam int AW       = $clog2(MAX_WIDTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [D_WIDTH-1:0] rdata
);

    logic [D_WIDTH-1:0] mem [MAX_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gl4_box2x2_prefilter.sv
// 2x2 box pre-filter ahead of the 2x2 decimator: each output is the rounded mean
// of the current pixel, its left neighbour and the two pixels above them.
module gl4_box2x2_prefilter
    import gl4_pkg::*;
#(
    parameter int D_WIDTH   = GL4_D_WIDTH,
    parameter int MAX_WIDTH = GL4_MAX_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    input  logic               up_tlast,
    input  logic               up_tuser,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    output logic               down_tlast,
    output logic               down_tuser,
    input  logic               down_ready,
    output logic               overflow
);

    localparam int AW = $clog2(MAX_WIDTH);
    localparam int SW = D_WIDTH + 2;
    localparam logic [AW-1:0] X_MAX = AW'(MAX_WIDTH - 1);

    logic               acc;
    logic [AW-1:0]      x;
    logic [AW-1:0]      addr;
    logic               first_line;
    logic               eff_first;
    logic               eff_x0;
    logic               x_sat;
    logic [D_WIDTH-1:0] cur_d;
    logic [D_WIDTH-1:0] above_d;
    logic [D_WIDTH-1:0] lb_rdata;
    logic [D_WIDTH-1:0] left;
    logic [D_WIDTH-1:0] above;
    logic [D_WIDTH-1:0] above_left;
    logic [SW-1:0]      sum;

    assign up_ready = ~down_valid | down_ready;
    assign acc      = up_valid & up_ready;

    // A tuser beat restarts the frame even mid-line, so it overrides position and line state.
    assign eff_x0    = up_tuser | (x == '0);
    assign eff_first = up_tuser | first_line;
    assign addr      = up_tuser ? '0 : x;
    assign x_sat     = (addr == X_MAX);

    gl4_line_buffer #(
        .D_WIDTH  (D_WIDTH),
        .MAX_WIDTH(MAX_WIDTH)
    ) u_line_buffer (
        .clk  (clk),
        .we   (acc),
        .waddr(addr),
        .wdata(up_data),
        .raddr(addr),
        .rdata(lb_rdata)
    );

    // Edge replication: missing left column copies the current column, missing top row copies the current row.
    assign left       = eff_x0 ? up_data : cur_d;
    assign above      = eff_first ? up_data : lb_rdata;
    assign above_left = eff_first ? left : (eff_x0 ? above : above_d);

    assign sum = SW'(up_data) + SW'(left) + SW'(above) + SW'(above_left);

    // Output register slice; state only advances on an accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            down_valid <= 1'b0;
            down_data  <= '0;
            down_tlast <= 1'b0;
            down_tuser <= 1'b0;
            overflow   <= 1'b0;
            x          <= '0;
            first_line <= 1'b1;
            cur_d      <= '0;
            above_d    <= '0;
        end else if (acc) begin
            down_valid <= 1'b1;
            down_data  <= D_WIDTH'(avg4(AVG_W'(sum)));
            down_tlast <= up_tlast;
            down_tuser <= up_tuser;
            cur_d      <= up_data;
            above_d    <= above;
            overflow   <= (overflow & ~up_tuser) | (~up_tlast & x_sat);
            if (up_tlast) begin
                x          <= '0;
                first_line <= 1'b0;
            end else begin
                x          <= x_sat ? X_MAX : addr + AW'(1);
                first_line <= eff_first;
            end
        end else if (down_ready) begin
            down_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gl4_box2x2_prefilter.sv
// Directed bench for gl4_box2x2_prefilter with hand-computed expected pixels.
module tb_gl4_box2x2_prefilter;

    localparam int D_WIDTH   = 8;
    localparam int MAX_WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [D_WIDTH-1:0] up_data;
    logic               up_valid;
    logic               up_tlast;
    logic               up_tuser;
    logic               up_ready;
    logic [D_WIDTH-1:0] down_data;
    logic               down_valid;
    logic               down_tlast;
    logic               down_tuser;
    logic               down_ready;
    logic               overflow;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] ramp     [4] = '{8'd0, 8'd4, 8'd8, 8'd12};
    logic [7:0] ramp_exp [4] = '{8'd0, 8'd2, 8'd6, 8'd10};
    logic [7:0] four     [4] = '{8'd4, 8'd4, 8'd4, 8'd4};
    logic [7:0] four_exp [4] = '{8'd2, 8'd3, 8'd5, 8'd7};
    logic [7:0] c40      [4] = '{8'h40, 8'h40, 8'h40, 8'h40};
    logic [7:0] cff      [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

    always #5 clk = ~clk;

    gl4_box2x2_prefilter #(
        .D_WIDTH  (D_WIDTH),
        .MAX_WIDTH(MAX_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_data   (up_data),
        .up_valid  (up_valid),
        .up_tlast  (up_tlast),
        .up_tuser  (up_tuser),
        .up_ready  (up_ready),
        .down_data (down_data),
        .down_valid(down_valid),
        .down_tlast(down_tlast),
        .down_tuser(down_tuser),
        .down_ready(down_ready),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic l, input logic u,
                        input logic [7:0] e, input string tag);
        up_data  = d;
        up_valid = 1'b1;
        up_tlast = l;
        up_tuser = u;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(down_valid), 32'd1);
        check({tag, ".data"},  32'(down_data),  32'(e));
        check({tag, ".tlast"}, 32'(down_tlast), 32'(l));
        check({tag, ".tuser"}, 32'(down_tuser), 32'(u));
    endtask

    task automatic line4(input logic [7:0] d [4], input logic [7:0] e [4],
                         input logic sof, input string tag);
        for (int i = 0; i < 4; i++) begin
            beat(d[i], (i == 3), sof && (i == 0), e[i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic idle(input int n);
        up_valid = 1'b0;
        up_tlast = 1'b0;
        up_tuser = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        up_data    = '0;
        up_valid   = 1'b0;
        up_tlast   = 1'b0;
        up_tuser   = 1'b0;
        down_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid",    32'(down_valid), 32'd0);
        check("rst.data",     32'(down_data),  32'd0);
        check("rst.tlast",    32'(down_tlast), 32'd0);
        check("rst.tuser",    32'(down_tuser), 32'd0);
        check("rst.overflow", 32'(overflow),   32'd0);
        check("rst.up_ready", 32'(up_ready),   32'd1);
        rst = 1'b1;
        idle(2);

        // Constant frame, 1-cycle latency and sideband alignment.
        line4(c40, c40, 1'b1, "const.l0");
        line4(c40, c40, 1'b0, "const.l1");
        idle(2);
        check("const.drain", 32'(down_valid), 32'd0);

        // Ramp then flat line.
        line4(ramp, ramp_exp, 1'b1, "ramp.l0");
        line4(four, four_exp, 1'b0, "ramp.l1");
        idle(1);

        // Full scale must not wrap.
        line4(cff, cff, 1'b1, "ff.l0");
        line4(cff, cff, 1'b0, "ff.l1");
        idle(1);

        // Single-pixel line (tlast+tuser), then a line using it as the row above.
        beat(8'h20, 1'b1, 1'b1, 8'h20, "onepix.l0");
        beat(8'h40, 1'b1, 1'b0, 8'h30, "onepix.l1");
        idle(1);

        // Back-pressure mid-line.
        line4(ramp, ramp_exp, 1'b1, "stall.l0");
        beat(four[0], 1'b0, 1'b0, four_exp[0], "stall.l1[0]");
        down_ready = 1'b0;
        up_data    = four[1];
        up_valid   = 1'b1;
        up_tlast   = 1'b0;
        up_tuser   = 1'b0;
        #1;
        check("stall.up_ready", 32'(up_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall.hold_data%0d", i),  32'(down_data),  32'(four_exp[0]));
            check($sformatf("stall.hold_valid%0d", i), 32'(down_valid), 32'd1);
            check($sformatf("stall.hold_ready%0d", i), 32'(up_ready),   32'd0);
        end
        down_ready = 1'b1;
        #1;
        check("stall.release_ready", 32'(up_ready), 32'd1);
        @(posedge clk);
        #1;
        check("stall.l1[1].data", 32'(down_data), 32'(four_exp[1]));
        beat(four[2], 1'b0, 1'b0, four_exp[2], "stall.l1[2]");
        beat(four[3], 1'b1, 1'b0, four_exp[3], "stall.l1[3]");
        idle(1);

        // Over-long line: x saturates at MAX_WIDTH-1 and the flag sticks.
        beat(8'h10, 1'b0, 1'b1, 8'h10, "ovf.b0");
        for (int i = 1; i < MAX_WIDTH + 2; i++) begin
            beat(8'h10, 1'b0, 1'b0, 8'h10, $sformatf("ovf.b%0d", i));
            if (i == MAX_WIDTH - 2) check("ovf.before_sat", 32'(overflow), 32'd0);
            if (i == MAX_WIDTH - 1) check("ovf.at_sat",     32'(overflow), 32'd1);
        end
        check("ovf.after_line", 32'(overflow), 32'd1);
        idle(3);
        check("ovf.sticky", 32'(overflow), 32'd1);
        beat(8'h10, 1'b1, 1'b1, 8'h10, "ovf.clear_beat");
        check("ovf.cleared", 32'(overflow), 32'd0);
        idle(1);

        // Asynchronous reset mid-line; the next line must be treated as a first line.
        beat(8'h80, 1'b0, 1'b1, 8'h80, "rstmid.b0");
        beat(8'h00, 1'b0, 1'b0, 8'h40, "rstmid.b1");
        up_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rstmid.valid",    32'(down_valid), 32'd0);
        check("rstmid.data",     32'(down_data),  32'd0);
        check("rstmid.up_ready", 32'(up_ready),   32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        line4(ramp, ramp_exp, 1'b0, "rstmid.l0");
        line4(four, four_exp, 1'b0, "rstmid.l1");
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
